// File: rtl/alu_pkg.sv
//============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, FSM state encoding and sizing helper for alu_seq.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
//============================================================================
// Module   : alu_seq_if
// Brief    : Issue/writeback valid-ready bundle around the sequential ALU.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface alu_seq_if #(parameter int W = 32);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   aluop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         overflow;

    modport master (
        output in_valid, a, b, aluop, out_ready,
        input  in_ready, out_valid, result, result_hi, overflow
    );

    modport slave (
        input  in_valid, a, b, aluop, out_ready,
        output in_ready, out_valid, result, result_hi, overflow
    );

endinterface

`default_nettype wire

// File: rtl/alu_seq_mul.sv
//============================================================================
// Module   : seq_mul
// Brief    : Iterative shift-add W x W -> 2W multiplier, one bit per cycle.
//            ALU_SIGNED_MUL_EN selects two's-complement operands.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module seq_mul
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start,
    input  wire logic [W-1:0]   a,
    input  wire logic [W-1:0]   b,
    output logic                done,
    output logic [2*W-1:0]      product
);

    localparam int CW = clog2(W);
    localparam logic [CW-1:0]  c_last    = CW'(W - 1);
    localparam logic [CW-1:0]  c_cnt_one = CW'(1);
    localparam logic [W-1:0]   c_one_w   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] c_one_p   = {{(2*W-1){1'b0}}, 1'b1};

    logic [W-1:0]   r_mcand;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_neg;

    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic           w_neg_in;
    logic [W:0]     w_add;
    logic [2*W-1:0] w_next;

`ifdef ALU_SIGNED_MUL_EN
    // Magnitude of -2^(W-1) is 2^(W-1), which still fits unsigned in W bits.
    assign w_mag_a  = a[W-1] ? (~a + c_one_w) : a;
    assign w_mag_b  = b[W-1] ? (~b + c_one_w) : b;
    assign w_neg_in = a[W-1] ^ b[W-1];
`else
    assign w_mag_a  = a;
    assign w_mag_b  = b;
    assign w_neg_in = 1'b0;
`endif

    // Upper half accumulates, lower half holds the remaining multiplier bits.
    assign w_add   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_next  = {w_add, r_acc[W-1:1]};

    // The final iteration's sum is presented directly so the product is ready in the last cycle.
    assign product = r_neg ? (~w_next + c_one_p) : w_next;
    assign done    = r_busy && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_neg   <= 1'b0;
        end else if (start) begin
            r_mcand <= w_mag_a;
            r_acc   <= {{W{1'b0}}, w_mag_b};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_neg   <= w_neg_in;
        end else if (r_busy) begin
            r_acc   <= w_next;
            r_cnt   <= r_cnt + c_cnt_one;
            if (r_cnt == c_last) r_busy <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//============================================================================
// Module   : alu_seq
// Brief    : W-bit ALU with sequential multiplier behind valid/ready handshakes.
//            Optional macro ALU_SIGNED_MUL_EN: signed MUL.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_seq_if.slave   bus
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_mul_start;
    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_accept;
    logic           w_is_mul;

    logic [W-1:0]   r_result;
    logic [W-1:0]   r_result_hi;
    logic           r_overflow;

    logic [W-1:0]   w_sum;
    logic [W-1:0]   w_diff;
    logic [W-1:0]   w_res;
    logic           w_ovf;

    logic           w_mul_done;
    logic [2*W-1:0] w_product;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_is_mul = (bus.aluop == OP_MUL);
    assign w_sum    = bus.a + bus.b;
    assign w_diff   = bus.a - bus.b;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (bus.aluop)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (bus.a[W-1] == bus.b[W-1]) && (w_sum[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (bus.a[W-1] != bus.b[W-1]) && (w_diff[W-1] != bus.a[W-1]);
            end
            OP_XOR: w_res = bus.a ^ bus.b;
            OP_NOR: w_res = ~(bus.a | bus.b);
            OP_AND: w_res = bus.a & bus.b;
            OP_OR:  w_res = bus.a | bus.b;
            OP_SLT: w_res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    seq_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (w_mul_done),
        .product (w_product)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_mul_start = w_is_mul;
                    w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (w_mul_done) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_overflow  <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result    <= w_res;
            r_result_hi <= '0;
            r_overflow  <= w_ovf;
        end else if ((r_state == ST_MUL) && w_mul_done) begin
            {r_result_hi, r_result} <= w_product;
            r_overflow              <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//============================================================================
// Module   : tb_alu_seq
// Brief    : Scoreboard bench for alu_seq at W=32 and W=8.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_if #(.W(32)) bus32();
    alu_seq_if #(.W(8))  bus8();

    alu_seq #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    alu_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        string       nm;
        logic [63:0] res;
        logic [63:0] hi;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb32[$];
    exp_t sb8[$];
    exp_t m32, m8;
    int   nvec = 0;
    int   nmis = 0;
    logic pv32 = 1'b0;
    logic pv8  = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitors: compare on the first cycle each result is presented.
    always @(negedge clk) begin
        if (rst) pv32 = 1'b0;
        else begin
            if (bus32.out_valid && !pv32) begin
                if (sb32.size() == 0) check("unexpected_out32", 64'd1, 64'd0);
                else begin
                    m32 = sb32.pop_front();
                    check({m32.nm, "_res"}, 64'(bus32.result), m32.res);
                    check({m32.nm, "_hi"},  64'(bus32.result_hi), m32.hi);
                    check({m32.nm, "_ovf"}, 64'(bus32.overflow), 64'(m32.ovf));
                    check({m32.nm, "_lat"}, 64'(cyc - m32.acc), 64'(m32.lat));
                end
            end
            pv32 = bus32.out_valid;
        end
    end

    always @(negedge clk) begin
        if (rst) pv8 = 1'b0;
        else begin
            if (bus8.out_valid && !pv8) begin
                if (sb8.size() == 0) check("unexpected_out8", 64'd1, 64'd0);
                else begin
                    m8 = sb8.pop_front();
                    check({m8.nm, "_res"}, 64'(bus8.result), m8.res);
                    check({m8.nm, "_hi"},  64'(bus8.result_hi), m8.hi);
                    check({m8.nm, "_ovf"}, 64'(bus8.overflow), 64'(m8.ovf));
                    check({m8.nm, "_lat"}, 64'(cyc - m8.acc), 64'(m8.lat));
                end
            end
            pv8 = bus8.out_valid;
        end
    end

    task automatic issue(input bit w8, input string nm, input logic [63:0] ia, input logic [63:0] ib,
                         input logic [2:0] op, input logic [63:0] er, input logic [63:0] eh,
                         input logic eo, input int el);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        if (w8) begin
            bus8.a = ia[7:0]; bus8.b = ib[7:0]; bus8.aluop = op; bus8.in_valid = 1'b1;
        end else begin
            bus32.a = ia[31:0]; bus32.b = ib[31:0]; bus32.aluop = op; bus32.in_valid = 1'b1;
        end
        while (!(w8 ? bus8.in_ready : bus32.in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(w8 ? bus8.in_ready : bus32.in_ready)) begin
            check({nm, "_accept_timeout"}, 64'd0, 64'd1);
            bus8.in_valid  = 1'b0;
            bus32.in_valid = 1'b0;
            return;
        end
        e.nm = nm; e.res = er; e.hi = eh; e.ovf = eo; e.lat = el; e.acc = cyc;
        if (w8) sb8.push_back(e);
        else    sb32.push_back(e);
        @(negedge clk);
        if (w8) bus8.in_valid = 1'b0;
        else    bus32.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb32.size() + sb8.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb32.size() + sb8.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  64'(bus32.in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(bus32.out_valid), 64'd0);
        check({tag, "_result"},    64'(bus32.result),    64'd0);
        check({tag, "_result_hi"}, 64'(bus32.result_hi), 64'd0);
        check({tag, "_overflow"},  64'(bus32.overflow),  64'd0);
    endtask

    localparam logic [63:0] c_A = 64'hFFFF_FFEC;   // -20
    localparam logic [63:0] c_B = 64'hFFFF_FFE7;   // -25

    initial begin
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.a = '0; bus32.b = '0; bus32.aluop = OP_ADD;
        bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b1; bus8.a  = '0; bus8.b  = '0; bus8.aluop  = OP_ADD;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        issue(0, "add",      c_A, c_B, OP_ADD, 64'hFFFF_FFD3, 64'd0, 1'b0, 1);
        issue(0, "sub",      c_A, c_B, OP_SUB, 64'h0000_0005, 64'd0, 1'b0, 1);
        issue(0, "xor",      c_A, c_B, OP_XOR, 64'h0000_000B, 64'd0, 1'b0, 1);
        issue(0, "nor",      c_A, c_B, OP_NOR, 64'h0000_0010, 64'd0, 1'b0, 1);
        issue(0, "and",      c_A, c_B, OP_AND, 64'hFFFF_FFE4, 64'd0, 1'b0, 1);
        issue(0, "or",       c_A, c_B, OP_OR,  64'hFFFF_FFEF, 64'd0, 1'b0, 1);
        issue(0, "slt",      c_A, c_B, OP_SLT, 64'h0000_0000, 64'd0, 1'b0, 1);
        issue(0, "slt_swap", c_B, c_A, OP_SLT, 64'h0000_0001, 64'd0, 1'b0, 1);
`ifdef ALU_SIGNED_MUL_EN
        issue(0, "mul",      c_A, c_B, OP_MUL, 64'd500, 64'h0000_0000, 1'b0, 33);
`else
        issue(0, "mul",      c_A, c_B, OP_MUL, 64'd500, 64'hFFFF_FFD3, 1'b0, 33);
`endif
        issue(0, "add_ovf", 64'h7FFF_FFFF, 64'd1, OP_ADD, 64'h8000_0000, 64'd0, 1'b1, 1);
        issue(0, "sub_ovf", 64'h8000_0000, 64'd1, OP_SUB, 64'h7FFF_FFFF, 64'd0, 1'b1, 1);
        drain();

        // Backpressure: result must hold and new requests must be ignored.
        bus32.out_ready = 1'b0;
        issue(0, "bp_add", 64'h10, 64'h20, OP_ADD, 64'h30, 64'd0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_result",    64'(bus32.result),    64'h30);
            check("bp_in_ready",  64'(bus32.in_ready),  64'd0);
            check("bp_out_valid", 64'(bus32.out_valid), 64'd1);
            bus32.a = 32'd5; bus32.b = 32'd5; bus32.aluop = OP_ADD; bus32.in_valid = 1'b1;
            @(negedge clk);
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready",  64'(bus32.in_ready),  64'd1);
        check("bp_release_out_valid", 64'(bus32.out_valid), 64'd0);
        repeat (2) @(negedge clk);
        check("bp_no_spurious", 64'(bus32.out_valid), 64'd0);

        // Reset in the 10th MUL cycle discards the operation.
        issue(0, "mul_rst", 64'd3, 64'd4, OP_MUL, 64'd12, 64'd0, 1'b0, 33);
        void'(sb32.pop_back());
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midmul_reset");
        issue(0, "add_after_rst", 64'd2, 64'd3, OP_ADD, 64'd5, 64'd0, 1'b0, 1);
        drain();

        issue(1, "mul8_min", 64'h80, 64'h80, OP_MUL, 64'h00, 64'h40, 1'b0, 9);
`ifdef ALU_SIGNED_MUL_EN
        issue(1, "mul8_neg", 64'h7F, 64'hFF, OP_MUL, 64'h81, 64'hFF, 1'b0, 9);
`else
        issue(1, "mul8_neg", 64'h7F, 64'hFF, OP_MUL, 64'h81, 64'h7E, 1'b0, 9);
`endif
        issue(1, "add8_ovf", 64'h7F, 64'h01, OP_ADD, 64'h80, 64'h00, 1'b1, 1);
        drain();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 100000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
